// File: rtl/count_chk_pkg.sv
// ---------------------------------------------------------------------------
// count_chk_pkg
// Shared definitions for the enable-counter checker slice.
//   DEF_WIDTH   : default width of the observed count bus
//   DEF_ERR_W   : default width of the saturating error counter
//   chk_state_t : checker FSM state encoding (IDLE / SYNC / TRACK)
// ---------------------------------------------------------------------------
package count_chk_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_ERR_W = 8;

  // IDLE  : no prediction, no compare
  // SYNC  : single cycle that seeds the prediction from the observed count
  // TRACK : compare every cycle and keep re-deriving the prediction
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_TRACK = 2'd2
  } chk_state_t;

endpackage

// File: rtl/count_checker_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating up-counter used for the checker's error count.
// Ports:
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset, clears the count
//   clr   : synchronous clear; an increment in the same cycle still counts,
//           so clr && inc leaves the counter at 1
//   inc   : increment request
//   count : current count, sticks at all-ones once reached
// ---------------------------------------------------------------------------
module sat_counter
  import count_chk_pkg::*;
#(
  parameter int W = DEF_ERR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = W'(1);
  localparam logic [W-1:0] MAX = '1;

  // Clear takes effect first, then the increment of the same cycle is
  // applied on top of it, so a coincident event is never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? ONE : '0;
    end else if (inc && (count != MAX)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/count_checker.sv
// ---------------------------------------------------------------------------
// count_checker
// Monitors a WIDTH-bit enable counter and flags every cycle where the
// observed count does not follow "+1 when enabled, hold when disabled,
// 0 while its reset is asserted".
// Ports:
//   CLK        : system clock, rising edge
//   RST        : synchronous active-high reset of the checker
//   ENABLE     : checker enable; low returns the FSM to IDLE
//   CLR_ERR    : one-cycle pulse clearing error count, sticky flag, capture
//   DUT_RST_X  : observed active-low reset of the counter under check
//   COUNTON_IN : observed counter enable
//   CNT_IN     : observed counter value
//   LOCKED     : high while tracking
//   MISMATCH   : one-cycle pulse, one cycle after a bad sample
//   STICKY_ERR : set by the first mismatch, held until cleared
//   ERR_CNT    : saturating mismatch count
//   EXP_CNT    : value predicted for the current cycle's CNT_IN
//   FIRST_EXP  : prediction at the first mismatch
//   FIRST_OBS  : observed value at the first mismatch
// ---------------------------------------------------------------------------
module count_checker
  import count_chk_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ERR_W = DEF_ERR_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ENABLE,
  input  logic             CLR_ERR,
  input  logic             DUT_RST_X,
  input  logic             COUNTON_IN,
  input  logic [WIDTH-1:0] CNT_IN,
  output logic             LOCKED,
  output logic             MISMATCH,
  output logic             STICKY_ERR,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic [WIDTH-1:0] EXP_CNT,
  output logic [WIDTH-1:0] FIRST_EXP,
  output logic [WIDTH-1:0] FIRST_OBS
);

  chk_state_t       state_q;
  chk_state_t       state_d;
  logic [WIDTH-1:0] exp_q;
  logic [WIDTH-1:0] exp_next;
  logic             predict_en;
  logic             compare_en;
  logic             mism;
  logic             clr;
  logic             mismatch_q;
  logic             sticky_q;
  logic [WIDTH-1:0] first_exp_q;
  logic [WIDTH-1:0] first_obs_q;

  // Qualifiers for this cycle. ENABLE low outranks both the clear and the
  // compare. A compare is masked while the observed counter is in reset,
  // because its value is forced rather than counted then.
  always_comb begin
    predict_en = ENABLE && (state_q != ST_IDLE);
    compare_en = ENABLE && (state_q == ST_TRACK) && DUT_RST_X;
    mism       = compare_en && (CNT_IN != exp_q);
    clr        = ENABLE && CLR_ERR;
    // The prediction is always rebuilt from what was just observed rather
    // than from the previous prediction, so one bad sample costs exactly
    // one mismatch and the checker re-locks onto the new value.
    exp_next   = DUT_RST_X ? (CNT_IN + WIDTH'(COUNTON_IN)) : '0;
  end

  // Next-state logic: SYNC always lasts a single cycle, and dropping ENABLE
  // from any state returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (ENABLE) state_d = ST_SYNC;
      ST_SYNC:  state_d = ENABLE ? ST_TRACK : ST_IDLE;
      ST_TRACK: if (!ENABLE) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register and prediction. The prediction is held while idle so
  // EXP_CNT stays stable; it is reloaded in SYNC and every TRACK cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      exp_q   <= '0;
    end else begin
      state_q <= state_d;
      if (predict_en) begin
        exp_q <= exp_next;
      end
    end
  end

  // Error reporting. A clear coincident with a mismatch wipes the old
  // capture and immediately records the new one, so the fresh failure is
  // never lost behind the clear.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mismatch_q  <= 1'b0;
      sticky_q    <= 1'b0;
      first_exp_q <= '0;
      first_obs_q <= '0;
    end else begin
      mismatch_q <= mism;
      if (clr) begin
        sticky_q    <= mism;
        first_exp_q <= mism ? exp_q  : '0;
        first_obs_q <= mism ? CNT_IN : '0;
      end else if (mism && !sticky_q) begin
        sticky_q    <= 1'b1;
        first_exp_q <= exp_q;
        first_obs_q <= CNT_IN;
      end
    end
  end

  sat_counter #(
    .W (ERR_W)
  ) u_err_cnt (
    .clk   (CLK),
    .rst   (RST),
    .clr   (clr),
    .inc   (mism),
    .count (ERR_CNT)
  );

  assign LOCKED     = (state_q == ST_TRACK);
  assign MISMATCH   = mismatch_q;
  assign STICKY_ERR = sticky_q;
  assign EXP_CNT    = exp_q;
  assign FIRST_EXP  = first_exp_q;
  assign FIRST_OBS  = first_obs_q;

endmodule

// File: tb/tb_count_checker.sv
// ---------------------------------------------------------------------------
// tb_count_checker
// Self-checking bench for count_checker. Two instances share the stimulus:
// one with the default 8-bit error counter and one with a 2-bit counter so
// saturation is reachable in a few faults.
// ---------------------------------------------------------------------------
module tb_count_checker;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       clr_err;
  logic       dut_rst_x;
  logic       counton;
  logic [3:0] cnt_in;

  logic       locked,   s_locked;
  logic       mismatch, s_mismatch;
  logic       sticky,   s_sticky;
  logic [7:0] err_cnt;
  logic [1:0] s_err_cnt;
  logic [3:0] exp_cnt,   s_exp_cnt;
  logic [3:0] first_exp, s_first_exp;
  logic [3:0] first_obs, s_first_obs;

  int check_count = 0;
  int pass_count  = 0;

  // Reference model state, describing the situation after each clock edge
  int         m_run;
  logic [3:0] m_exp;
  bit         m_mis;
  bit         m_sticky;
  int         m_err_total;
  logic [3:0] m_first_exp;
  logic [3:0] m_first_obs;

  typedef struct {
    logic       rst, en, clr, rst_x, on;
    logic [3:0] cnt;
    logic       locked, mis, sticky;
    int         err;
    logic [3:0] exp_cnt, first_exp, first_obs;
  } vec_t;

  vec_t vecs[$];

  count_checker #(.WIDTH(4), .ERR_W(8)) dut (
    .CLK(clk), .RST(rst), .ENABLE(enable), .CLR_ERR(clr_err),
    .DUT_RST_X(dut_rst_x), .COUNTON_IN(counton), .CNT_IN(cnt_in),
    .LOCKED(locked), .MISMATCH(mismatch), .STICKY_ERR(sticky),
    .ERR_CNT(err_cnt), .EXP_CNT(exp_cnt),
    .FIRST_EXP(first_exp), .FIRST_OBS(first_obs)
  );

  count_checker #(.WIDTH(4), .ERR_W(2)) dut_sat (
    .CLK(clk), .RST(rst), .ENABLE(enable), .CLR_ERR(clr_err),
    .DUT_RST_X(dut_rst_x), .COUNTON_IN(counton), .CNT_IN(cnt_in),
    .LOCKED(s_locked), .MISMATCH(s_mismatch), .STICKY_ERR(s_sticky),
    .ERR_CNT(s_err_cnt), .EXP_CNT(s_exp_cnt),
    .FIRST_EXP(s_first_exp), .FIRST_OBS(s_first_obs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(int r, int e, int c, int rx, int o, int n,
                              int lk, int mi, int st, int er, int ex,
                              int fe, int fo);
    vec_t v;
    v.rst = r[0]; v.en = e[0]; v.clr = c[0]; v.rst_x = rx[0]; v.on = o[0];
    v.cnt = 4'(n);
    v.locked = lk[0]; v.mis = mi[0]; v.sticky = st[0]; v.err = er;
    v.exp_cnt = 4'(ex); v.first_exp = 4'(fe); v.first_obs = 4'(fo);
    return v;
  endfunction

  task automatic checkVal(input string name, input int act, input int req);
    check_count++;
    if (act == req) pass_count++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // Behavioural rules: the checker tracks once it has seen two consecutive
  // enabled cycles; the value expected next is what the counter should do
  // with what it showed this cycle; a clear happens before the count.
  task automatic modelStep(input logic r, e, c, rx, o, input logic [3:0] n);
    bit bad;
    if (r) begin
      m_run = 0; m_exp = 4'd0; m_mis = 0; m_sticky = 0;
      m_err_total = 0; m_first_exp = 4'd0; m_first_obs = 4'd0;
    end else if (!e) begin
      m_run = 0;
      m_mis = 0;
    end else begin
      bad = (m_run >= 2) && rx && (n != m_exp);
      if (c) begin
        m_err_total = 0; m_sticky = 0; m_first_exp = 4'd0; m_first_obs = 4'd0;
      end
      if (bad) begin
        m_err_total++;
        if (!m_sticky) begin
          m_sticky = 1; m_first_exp = m_exp; m_first_obs = n;
        end
      end
      m_mis = bad;
      if (m_run >= 1) m_exp = rx ? 4'((int'(n) + int'(o)) % 16) : 4'd0;
      if (m_run < 2) m_run++;
    end
  endtask

  task automatic applyStimulus(input logic r, e, c, rx, o, input logic [3:0] n);
    rst = r; enable = e; clr_err = c; dut_rst_x = rx; counton = o; cnt_in = n;
    @(posedge clk);
    modelStep(r, e, c, rx, o, n);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int lk, mi, st, er,
                             input int ex, fe, fo);
    checkVal({tag, ".locked"},     int'(locked),     lk);
    checkVal({tag, ".mismatch"},   int'(mismatch),   mi);
    checkVal({tag, ".sticky"},     int'(sticky),     st);
    checkVal({tag, ".err_cnt"},    int'(err_cnt),    (er > 255) ? 255 : er);
    checkVal({tag, ".exp_cnt"},    int'(exp_cnt),    ex);
    checkVal({tag, ".first_exp"},  int'(first_exp),  fe);
    checkVal({tag, ".first_obs"},  int'(first_obs),  fo);
    checkVal({tag, ".s_locked"},   int'(s_locked),   lk);
    checkVal({tag, ".s_mismatch"}, int'(s_mismatch), mi);
    checkVal({tag, ".s_sticky"},   int'(s_sticky),   st);
    checkVal({tag, ".s_err_cnt"},  int'(s_err_cnt),  (er > 3) ? 3 : er);
    checkVal({tag, ".s_exp_cnt"},  int'(s_exp_cnt),  ex);
    checkVal({tag, ".s_first_exp"}, int'(s_first_exp), fe);
    checkVal({tag, ".s_first_obs"}, int'(s_first_obs), fo);
  endtask

  task automatic checkModel(input string tag);
    checkOutput(tag, (m_run >= 2) ? 1 : 0, int'(m_mis), int'(m_sticky),
                m_err_total, int'(m_exp), int'(m_first_exp), int'(m_first_obs));
  endtask

  initial begin
    int sim_next;
    logic r, e, c, rx, o;
    logic [3:0] n;

    rst = 1'b1; enable = 1'b0; clr_err = 1'b0;
    dut_rst_x = 1'b1; counton = 1'b0; cnt_in = 4'd0;

    //           rst en clr rx on cnt | lk mis st err exp fe fo
    vecs.push_back(mk(1, 0, 0, 1, 0,  0,  0, 0, 0, 0,  0, 0, 0)); // reset
    vecs.push_back(mk(0, 1, 0, 1, 1, 13,  0, 0, 0, 0,  0, 0, 0)); // idle->sync
    vecs.push_back(mk(0, 1, 0, 1, 1, 14,  1, 0, 0, 0, 15, 0, 0)); // sync seeds
    vecs.push_back(mk(0, 1, 0, 1, 1, 15,  1, 0, 0, 0,  0, 0, 0)); // wrap
    vecs.push_back(mk(0, 1, 0, 1, 1,  0,  1, 0, 0, 0,  1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 0,  1,  1, 0, 0, 0,  1, 0, 0)); // hold
    vecs.push_back(mk(0, 1, 0, 1, 0,  1,  1, 0, 0, 0,  1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 0,  2,  1, 1, 1, 1,  2, 1, 2)); // step while off
    vecs.push_back(mk(0, 1, 0, 1, 1,  2,  1, 0, 1, 1,  3, 1, 2));
    vecs.push_back(mk(0, 1, 0, 1, 1,  4,  1, 1, 1, 2,  5, 1, 2)); // skip 3->4? no, 3 expected
    vecs.push_back(mk(0, 1, 0, 1, 1,  5,  1, 0, 1, 2,  6, 1, 2)); // next accepted
    vecs.push_back(mk(0, 1, 0, 0, 1,  0,  1, 0, 1, 2,  0, 1, 2)); // dut reset masked
    vecs.push_back(mk(0, 1, 0, 0, 1,  0,  1, 0, 1, 2,  0, 1, 2));
    vecs.push_back(mk(0, 1, 0, 1, 1,  0,  1, 0, 1, 2,  1, 1, 2)); // released
    vecs.push_back(mk(0, 1, 0, 1, 1,  1,  1, 0, 1, 2,  2, 1, 2));
    vecs.push_back(mk(0, 1, 1, 1, 1,  7,  1, 1, 1, 1,  8, 2, 7)); // clear + fault
    vecs.push_back(mk(0, 1, 1, 1, 1,  8,  1, 0, 0, 0,  9, 0, 0)); // clear alone
    vecs.push_back(mk(0, 0, 0, 1, 1,  9,  0, 0, 0, 0,  9, 0, 0)); // enable low
    vecs.push_back(mk(0, 1, 0, 1, 1, 10,  0, 0, 0, 0,  9, 0, 0)); // idle->sync
    vecs.push_back(mk(0, 1, 0, 1, 1,  3,  1, 0, 0, 0,  4, 0, 0)); // bad in sync ignored
    vecs.push_back(mk(0, 1, 0, 1, 1,  4,  1, 0, 0, 0,  5, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 1,  9,  1, 1, 1, 1, 10, 5, 9));
    vecs.push_back(mk(1, 1, 0, 1, 1, 10,  0, 0, 0, 0,  0, 0, 0)); // reset mid-track
    vecs.push_back(mk(0, 1, 0, 1, 1,  0,  0, 0, 0, 0,  0, 0, 0));

    $display("[TB] directed vectors: %0d", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].clr, vecs[i].rst_x,
                    vecs[i].on, vecs[i].cnt);
      checkOutput($sformatf("vec%0d", i), int'(vecs[i].locked),
                  int'(vecs[i].mis), int'(vecs[i].sticky), vecs[i].err,
                  int'(vecs[i].exp_cnt), int'(vecs[i].first_exp),
                  int'(vecs[i].first_obs));
    end

    // Saturation: five consecutive faults after a fresh SYNC from 0
    applyStimulus(0, 1, 0, 1, 0, 4'd0);
    checkModel("sat_sync");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1, 0, 1, 0, 4'(i + 1));
      checkModel($sformatf("sat_fault%0d", i));
    end
    checkVal("sat.err_cnt8", int'(err_cnt), 5);
    checkVal("sat.err_cnt2", int'(s_err_cnt), 3);
    checkVal("sat.first_exp", int'(first_exp), 0);
    checkVal("sat.first_obs", int'(first_obs), 1);

    // Clear coincident with a fault on the saturated counter
    applyStimulus(0, 1, 1, 1, 0, 4'd9);
    checkVal("clrfault.err_cnt2", int'(s_err_cnt), 1);
    checkVal("clrfault.sticky", int'(s_sticky), 1);
    checkVal("clrfault.first_exp", int'(s_first_exp), 5);
    checkVal("clrfault.first_obs", int'(s_first_obs), 9);
    checkModel("clrfault");

    // Randomised run against the model, counter mostly well-behaved
    applyStimulus(1, 0, 0, 1, 0, 4'd0);
    checkModel("rnd_reset");
    sim_next = 0;
    for (int i = 0; i < 800; i++) begin
      r  = ($urandom_range(0, 99) == 0);
      e  = ($urandom_range(0, 19) != 0);
      c  = ($urandom_range(0, 24) == 0);
      rx = ($urandom_range(0, 9) != 0);
      o  = 1'($urandom_range(0, 1));
      if (!rx) n = 4'd0;
      else if ($urandom_range(0, 9) == 0) n = 4'($urandom_range(0, 15));
      else n = 4'(sim_next);
      sim_next = rx ? ((int'(n) + int'(o)) % 16) : 0;
      applyStimulus(r, e, c, rx, o, n);
      checkModel($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/count_checker.md
Name: count_checker

Overview:
- Hardware-side monitor and checker for the 4-bit enable counter. It observes the counter's reset, COUNTON and CNT4 each cycle and checks that the count advances by exactly +1 (mod 2^WIDTH) when enabled, holds when disabled, and returns to 0 after reset.
- Mismatch pulses, a saturating error count and first-failure capture replace file-based output logging for self-checking simulation and on-chip debug.

Parameters:
- WIDTH, 4, width of the observed count bus.
- ERR_W, 8, width of the saturating error counter.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RST  input  1  synchronous, active-high reset of the checker itself.
- ENABLE  input  1  checker enable; low forces IDLE.
- CLR_ERR  input  1  one-cycle pulse; clears error state.
- DUT_RST_X  input  1  observed active-low reset of the counter under check.
- COUNTON_IN  input  1  observed counter enable.
- CNT_IN  input  WIDTH  observed counter value.
- LOCKED  output  1  high while in TRACK.
- MISMATCH  output  1  one-cycle pulse per detected mismatch.
- STICKY_ERR  output  1  set on first mismatch; held until CLR_ERR or RST.
- ERR_CNT  output  ERR_W  mismatch count; saturates at all-ones.
- EXP_CNT  output  WIDTH  value predicted for the current cycle's CNT_IN.
- FIRST_EXP  output  WIDTH  expected value at the first mismatch.
- FIRST_OBS  output  WIDTH  observed value at the first mismatch.

Behaviour:
- Reset: the clock is CLK and reset is RST, synchronous and active-high. RST=1 at a CLK edge sets state=IDLE and drives all outputs to 0 on the next cycle. RST mid-TRACK discards the prediction; no MISMATCH is issued for that cycle.
- States:
  - IDLE: no compares. ENABLE=1 -> SYNC.
  - SYNC: lasts exactly one cycle with no compare. Loads the prediction, then -> TRACK.
  - TRACK: compares every cycle. ENABLE=0 -> IDLE; LOCKED drops on the next cycle.
- Prediction rule, applied in SYNC and every TRACK cycle:
  - exp_next = 0 if DUT_RST_X=0.
  - Otherwise exp_next = CNT_IN + COUNTON_IN, modulo 2^WIDTH.
  - Wrap-around: CNT_IN=15 with COUNTON_IN=1 predicts 0.
  - The prediction is rebuilt from the observed value, so a single fault produces exactly one mismatch.
- Compare (TRACK only):
  - Skipped in any cycle where DUT_RST_X=0 (reset assertion is masked).
  - Otherwise, CNT_IN != EXP_CNT produces MISMATCH=1 on the next cycle (one-cycle registered latency) and increments ERR_CNT, holding at 2^ERR_W-1.
- First-failure capture: on a mismatch with STICKY_ERR=0, FIRST_EXP<=EXP_CNT, FIRST_OBS<=CNT_IN and STICKY_ERR<=1. Later mismatches do not overwrite the capture.
- CLR_ERR:
  - Zeroes ERR_CNT, STICKY_ERR, FIRST_EXP and FIRST_OBS. It does not change state or the prediction.
  - If a mismatch occurs in the same cycle, it is counted after the clear: ERR_CNT=1, STICKY_ERR=1, with the new capture.
- Priority: RST > ENABLE=0 > CLR_ERR > compare.
- Inputs are sampled synchronously to CLK; no synchronisers are included.

Decomposition:
- Shared package `count_chk_pkg`: state encoding constants ST_IDLE=2'd0, ST_SYNC=2'd1, ST_TRACK=2'd2, plus default WIDTH and ERR_W.
- One natural sub-module, `sat_counter` (ERR_W wide, with inc, clr and saturate), used for ERR_CNT.
- The FSM and prediction logic stay in the top-level module.

Test Plan:
- Clean count: ENABLE=1, DUT counts 0..15->0 with COUNTON=1 for 40 cycles -> LOCKED=1 from cycle 2, MISMATCH never asserted, ERR_CNT=0.
- Hold: COUNTON=0 for 5 cycles at CNT=7, CNT_IN stays 7 -> no mismatch. Then inject CNT_IN=8 while COUNTON=0 -> one MISMATCH pulse, ERR_CNT=1, FIRST_EXP=7, FIRST_OBS=8.
- DUT reset: DUT_RST_X=0 for 2 cycles at CNT=11 (CNT_IN=0), then released with COUNTON=1 -> no mismatch, EXP_CNT sequence 0,1,2.
- Skip fault: CNT_IN jumps 3->5 with COUNTON=1 -> exactly one MISMATCH, FIRST_EXP=4, FIRST_OBS=5, and the following 6 is accepted.
- Saturation and clear: ERR_W=2 with 5 injected faults -> ERR_CNT=3. Then CLR_ERR coincident with a fault -> ERR_CNT=1, STICKY_ERR=1, capture refreshed.
- Checker reset and enable: RST mid-TRACK -> all outputs 0 on the next cycle, state=IDLE. ENABLE toggled low then high -> one SYNC cycle with no compare, and a bad CNT_IN in the SYNC cycle is not flagged.
